// File: rtl/four_phase_receiver_pkg.sv
// four_phase_receiver_pkg: shared data width and FSM state encodings for the 4-phase receiver.
package four_phase_receiver_pkg;
    localparam int DATA_MSB = 7;
    typedef enum logic [1:0] {
        RX_RST     = 2'b00,
        RX_IDLE    = 2'b01,
        RX_ACKED   = 2'b10,
        RX_RELEASE = 2'b11
    } rx_state_t;
endpackage

// File: rtl/four_phase_receiver_dff.sv
// four_phase_receiver_dff: single synchronizer stage with synchronous active-high reset.
module four_phase_receiver_dff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk) q <= reset ? 1'b0 : d;
endmodule

// File: rtl/four_phase_receiver.sv
// four_phase_receiver: 4-phase push-handshake receiver with req synchronizer, Rx buffer and back-pressure.
// RX_SYNC3_EN adds a third synchronizer stage ahead of the FSM and the edge detector.
module four_phase_receiver
    import four_phase_receiver_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [DATA_MSB:0] input_rx,
    input  logic              take,
    output logic [DATA_MSB:0] output_rx,
    output logic              v,
    output logic              ack,
    output logic              f
);
    logic      w_r1, w_r2, w_sync, w_ack_nxt, w_cap;
    logic      r_r3;
    rx_state_t r_state, w_state_nxt;
    four_phase_receiver_dff u_s1 (.clk(clk), .reset(reset), .d(req),  .q(w_r1));
    four_phase_receiver_dff u_s2 (.clk(clk), .reset(reset), .d(w_r1), .q(w_r2));
`ifdef RX_SYNC3_EN
    four_phase_receiver_dff u_s3 (.clk(clk), .reset(reset), .d(w_r2), .q(w_sync));
`else
    assign w_sync = w_r2;
`endif
    always_comb begin
        w_state_nxt = RX_IDLE;
        w_ack_nxt   = 1'b0;
        w_cap       = 1'b0;
        case (r_state)
            RX_RST:     w_state_nxt = RX_IDLE;
            RX_IDLE: begin
                // a full, untaken buffer holds ack low so the transmitter waits
                w_cap       = w_sync && (!v || take);
                w_ack_nxt   = w_cap;
                w_state_nxt = w_cap ? RX_ACKED : RX_IDLE;
            end
            RX_ACKED: begin
                w_ack_nxt   = w_sync;
                w_state_nxt = w_sync ? RX_ACKED : RX_RELEASE;
            end
            RX_RELEASE: w_state_nxt = RX_IDLE;
            default:    w_state_nxt = RX_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RX_RST;
            output_rx <= '0;
            v         <= 1'b0;
            ack       <= 1'b0;
            f         <= 1'b0;
            r_r3      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            ack     <= w_ack_nxt;
            v       <= w_cap | (v & ~take);
            if (w_cap) output_rx <= input_rx;
            r_r3    <= w_sync;
            f       <= w_sync & ~r_r3;
        end
    end
endmodule

// File: tb/tb_four_phase_receiver.sv
// tb_four_phase_receiver: cycle table for the default build plus latency, back-to-back and mid-reset sequences.
module tb_four_phase_receiver;
    import four_phase_receiver_pkg::*;
`ifdef RX_SYNC3_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req = 1'b0;
    logic              take = 1'b0;
    logic [DATA_MSB:0] input_rx = '0;
    logic [DATA_MSB:0] output_rx;
    logic              v, ack, f;
    int                tests = 0;
    int                failed = 0;
    int                delivered = 0;
    bit                mon_en = 1'b0;
    logic              prev_ack = 1'b0;
    logic [7:0]        sb[$];
    typedef struct {
        logic       rst;
        logic       rq;
        logic [7:0] d;
        logic       tk;
        logic [7:0] eo;
        logic       ev;
        logic       ea;
        logic       ef;
    } vec_t;
    vec_t tbl[26];

    always #5 clk = ~clk;

    four_phase_receiver dut (
        .clk(clk), .reset(reset), .req(req), .input_rx(input_rx), .take(take),
        .output_rx(output_rx), .v(v), .ack(ack), .f(f)
    );

    function automatic vec_t mk(logic rst, logic rq, logic [7:0] d, logic tk,
                                logic [7:0] eo, logic ev, logic ea, logic ef);
        mk = '{rst, rq, d, tk, eo, ev, ea, ef};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        int n = 0;
        while (ack !== lvl && n < 30) begin
            step();
            n++;
        end
        chk(name, ack, lvl);
    endtask

    // scoreboard consumer: every ack rising edge marks one captured word
    always @(posedge clk) begin
        #1;
        if (mon_en && ack && !prev_ack) begin
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL b2b.unexpected: captured %0h, nothing was sent", output_rx);
            end else begin
                chk("b2b.data", output_rx, sb.pop_front());
                chk("b2b.v", v, 1'b1);
                delivered++;
            end
        end
        prev_ack = ack;
    end

    initial begin
        tbl[0]  = mk(1, 1, 8'h3C, 0, 8'h00, 0, 0, 0);
        tbl[1]  = mk(1, 1, 8'h3C, 0, 8'h00, 0, 0, 0);
        tbl[2]  = mk(1, 1, 8'h3C, 0, 8'h00, 0, 0, 0);
        tbl[3]  = mk(0, 1, 8'h3C, 0, 8'h00, 0, 0, 0);
        tbl[4]  = mk(0, 1, 8'h3C, 0, 8'h00, 0, 0, 0);
        tbl[5]  = mk(0, 1, 8'h3C, 0, 8'h3C, 1, 1, 1);
        tbl[6]  = mk(0, 0, 8'h3C, 1, 8'h3C, 0, 1, 0);
        tbl[7]  = mk(0, 0, 8'h3C, 0, 8'h3C, 0, 1, 0);
        tbl[8]  = mk(0, 0, 8'h3C, 0, 8'h3C, 0, 0, 0);
        tbl[9]  = mk(0, 0, 8'h3C, 0, 8'h3C, 0, 0, 0);
        tbl[10] = mk(0, 0, 8'h3C, 1, 8'h3C, 0, 0, 0);
        tbl[11] = mk(0, 1, 8'h11, 0, 8'h3C, 0, 0, 0);
        tbl[12] = mk(0, 1, 8'h11, 0, 8'h3C, 0, 0, 0);
        tbl[13] = mk(0, 1, 8'h11, 0, 8'h11, 1, 1, 1);
        tbl[14] = mk(0, 0, 8'h11, 0, 8'h11, 1, 1, 0);
        tbl[15] = mk(0, 0, 8'h11, 0, 8'h11, 1, 1, 0);
        tbl[16] = mk(0, 0, 8'h11, 0, 8'h11, 1, 0, 0);
        tbl[17] = mk(0, 1, 8'h22, 0, 8'h11, 1, 0, 0);
        tbl[18] = mk(0, 1, 8'h22, 0, 8'h11, 1, 0, 0);
        tbl[19] = mk(0, 1, 8'h22, 0, 8'h11, 1, 0, 1);
        tbl[20] = mk(0, 1, 8'h22, 0, 8'h11, 1, 0, 0);
        tbl[21] = mk(0, 1, 8'h22, 1, 8'h22, 1, 1, 0);
        tbl[22] = mk(0, 0, 8'h22, 0, 8'h22, 1, 1, 0);
        tbl[23] = mk(0, 0, 8'h22, 0, 8'h22, 1, 1, 0);
        tbl[24] = mk(0, 0, 8'h22, 0, 8'h22, 1, 0, 0);
        tbl[25] = mk(0, 0, 8'h22, 1, 8'h22, 0, 0, 0);
`ifndef RX_SYNC3_EN
        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            req = tbl[i].rq;
            input_rx = tbl[i].d;
            take = tbl[i].tk;
            step();
            chk($sformatf("row%0d.out", i), output_rx, tbl[i].eo);
            chk($sformatf("row%0d.v", i), v, tbl[i].ev);
            chk($sformatf("row%0d.ack", i), ack, tbl[i].ea);
            chk($sformatf("row%0d.f", i), f, tbl[i].ef);
        end
`endif
        reset = 1'b1; req = 1'b0; take = 1'b0;
        step();
        chk("rst.out", output_rx, 8'h00);
        chk("rst.v", v, 1'b0);
        chk("rst.ack", ack, 1'b0);
        step();
        reset = 1'b0;
        step();
        step();
        input_rx = 8'hA5;
        req = 1'b1;
        for (int k = 0; k < 2 + LAT; k++) begin
            step();
            chk("lat.ack_early", ack, 1'b0);
            chk("lat.f_early", f, 1'b0);
        end
        step();
        chk("lat.ack", ack, 1'b1);
        chk("lat.v", v, 1'b1);
        chk("lat.out", output_rx, 8'hA5);
        chk("lat.f", f, 1'b1);
        step();
        chk("lat.f_once", f, 1'b0);
        chk("lat.ack_hold", ack, 1'b1);
        req = 1'b0;
        for (int k = 0; k < 2 + LAT; k++) begin
            step();
            chk("lat.ack_still", ack, 1'b1);
        end
        step();
        chk("lat.ack_fall", ack, 1'b0);
        step();
        chk("lat.release_low", ack, 1'b0);
        take = 1'b1;
        mon_en = 1'b1;
        for (int w = 1; w <= 8; w++) begin
            input_rx = 8'(w);
            req = 1'b1;
            sb.push_back(8'(w));
            wait_ack(1'b1, "b2b.ack_hi");
            req = 1'b0;
            wait_ack(1'b0, "b2b.ack_lo");
            step();
        end
        mon_en = 1'b0;
        chk("b2b.count", delivered, 8);
        chk("b2b.left", sb.size(), 0);
        take = 1'b0;
        input_rx = 8'h5A;
        req = 1'b1;
        wait_ack(1'b1, "mr.ack_hi");
        chk("mr.out_first", output_rx, 8'h5A);
        step();
        reset = 1'b1;
        step();
        chk("mr.ack", ack, 1'b0);
        chk("mr.v", v, 1'b0);
        chk("mr.out", output_rx, 8'h00);
        chk("mr.f", f, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 2 + LAT; k++) begin
            step();
            chk("mr.ack_wait", ack, 1'b0);
        end
        step();
        chk("mr.recap_ack", ack, 1'b1);
        chk("mr.recap_v", v, 1'b1);
        chk("mr.recap_out", output_rx, 8'h5A);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("mr.single", ack, 1'b1);
        end
        req = 1'b0;
        repeat (4 + LAT) step();
        chk("mr.ack_end", ack, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
